// File: rtl/riscv_cpu_pkg.sv
// Shared CPU-wide constants for the integer register file and its scoreboard.
//   DATA_WIDTH   : architectural register width
//   ADDR_WIDTH   : register index width
//   NUM_REGS_DEF : default number of architectural registers (x0 hardwired 0)
//   PEND_W_DEF   : default width of the per-register pending-write counter
package riscv_cpu_pkg;
  localparam int DATA_WIDTH   = 32;
  localparam int ADDR_WIDTH   = 5;
  localparam int NUM_REGS_DEF = 32;
  localparam int PEND_W_DEF   = 2;
endpackage

// File: rtl/regfile_scoreboard_sb_counter.sv
// sb_counter: one register's count of in-flight writes.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : synchronous clear (flush), wins over inc/dec
//   inc_i, dec_i  : issue of a writer / retire of a writer
//   cnt_o         : current count
//   max_o         : count is at its saturation value
module sb_counter
  import riscv_cpu_pkg::*;
#(
  parameter int W = PEND_W_DEF
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         max_o
);
  localparam logic [W-1:0] CNT_MAX = '1;

  assign max_o = (cnt_o == CNT_MAX);

  // inc and dec together cancel; the guards keep the counter from wrapping
  // even if a caller forgets to gate inc/dec.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                              cnt_o <= '0;
    else if (clr_i)                           cnt_o <= '0;
    else if (inc_i && !dec_i && !max_o)       cnt_o <= cnt_o + 1'b1;
    else if (dec_i && !inc_i && cnt_o != '0)  cnt_o <= cnt_o - 1'b1;
  end
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: integer register file with per-register pending-write
// counters so decode can detect RAW hazards on operands still in flight.
//   clk_i, rst_ni               : clock, async active-low reset
//   we_i, waddr_i, wdata_i      : write-back port (also retires a pending write)
//   raddr_a_i, re_a_i, rdata_a_o: read port A (combinational, with bypass)
//   raddr_b_i, re_b_i, rdata_b_o: read port B (combinational, with bypass)
//   issue_i, issue_we_i,
//   issue_rd_i                  : decode issue; marks the destination pending
//   flush_i                     : clears every pending counter
//   hazard_o                    : a used operand still waits on a write
//   issue_ready_o               : destination counter can take another writer
module regfile_scoreboard
  import riscv_cpu_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int PEND_W   = PEND_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic                  re_a_i,
  output logic [DATA_WIDTH-1:0] rdata_a_o,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic                  re_b_i,
  output logic [DATA_WIDTH-1:0] rdata_b_o,
  input  logic                  issue_i,
  input  logic                  issue_we_i,
  input  logic [ADDR_WIDTH-1:0] issue_rd_i,
  input  logic                  flush_i,
  output logic                  hazard_o,
  output logic                  issue_ready_o
);
  logic [NUM_REGS-1:1][DATA_WIDTH-1:0] regs;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] rf_view;
  logic [NUM_REGS-1:0][PEND_W-1:0]     cnt;
  logic [NUM_REGS-1:0]                 at_max, inc, dec;
  logic                                we_hit, hz_a, hz_b;

  assign we_hit = we_i && (waddr_i != '0);

  // ---- storage: x0 has no flop ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs <= '0;
    end else if (we_hit) begin
      for (int r = 1; r < NUM_REGS; r++)
        if (waddr_i == ADDR_WIDTH'(r)) regs[r] <= wdata_i;
    end
  end

  always_comb begin
    rf_view    = '0;
    for (int r = 1; r < NUM_REGS; r++) rf_view[r] = regs[r];
  end

  // Write-through bypass so a retiring write is usable the same cycle.
  assign rdata_a_o = (we_hit && waddr_i == raddr_a_i) ? wdata_i : rf_view[raddr_a_i];
  assign rdata_b_o = (we_hit && waddr_i == raddr_b_i) ? wdata_i : rf_view[raddr_b_i];

  // ---- scoreboard ----
  assign cnt[0]    = '0;
  assign at_max[0] = 1'b0;

  // Ready only drops when the counter is full and nothing retires on it now.
  assign issue_ready_o = !(issue_we_i && issue_rd_i != '0 &&
                           at_max[issue_rd_i] && !dec[issue_rd_i]);

  always_comb begin
    inc = '0;
    dec = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      dec[r] = we_hit && (waddr_i == ADDR_WIDTH'(r)) && (cnt[r] != '0);
      inc[r] = issue_i && issue_we_i && (issue_rd_i != '0) && issue_ready_o &&
               (issue_rd_i == ADDR_WIDTH'(r)) && !flush_i;
    end
  end

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    sb_counter #(.W(PEND_W)) u_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (flush_i),
      .inc_i  (inc[r]),
      .dec_i  (dec[r]),
      .cnt_o  (cnt[r]),
      .max_o  (at_max[r])
    );
  end

  // A write retiring the last pending writer masks the hazard: bypass covers it.
  assign hz_a = re_a_i && (raddr_a_i != '0) && (cnt[raddr_a_i] != '0) &&
                !(we_i && waddr_i == raddr_a_i && cnt[raddr_a_i] == PEND_W'(1));
  assign hz_b = re_b_i && (raddr_b_i != '0) && (cnt[raddr_b_i] != '0) &&
                !(we_i && waddr_i == raddr_b_i && cnt[raddr_b_i] == PEND_W'(1));
  assign hazard_o = hz_a || hz_b;
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed, table-driven bench for regfile_scoreboard.
module tb_regfile_scoreboard;
  logic        clk = 1'b0;
  logic        rst_ni;
  logic        we_i;
  logic [4:0]  waddr_i;
  logic [31:0] wdata_i;
  logic [4:0]  raddr_a_i, raddr_b_i, issue_rd_i;
  logic        re_a_i, re_b_i, issue_i, issue_we_i, flush_i;
  logic [31:0] rdata_a_o, rdata_b_o;
  logic        hazard_o, issue_ready_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .raddr_a_i(raddr_a_i), .re_a_i(re_a_i), .rdata_a_o(rdata_a_o),
    .raddr_b_i(raddr_b_i), .re_b_i(re_b_i), .rdata_b_o(rdata_b_o),
    .issue_i(issue_i), .issue_we_i(issue_we_i), .issue_rd_i(issue_rd_i),
    .flush_i(flush_i), .hazard_o(hazard_o), .issue_ready_o(issue_ready_o)
  );

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  ra;
    logic        rea;
    logic [4:0]  rb;
    logic        reb;
    logic        iss, iwe;
    logic [4:0]  ird;
    logic        fl;
    logic [31:0] ea, eb;
    logic        ehz, erdy;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input int we, input int wa, input logic [31:0] wd,
                              input int ra, input int rea, input int rb, input int reb,
                              input int iss, input int iwe, input int ird, input int fl,
                              input logic [31:0] ea, input logic [31:0] eb,
                              input int hz, input int rdy);
    vec_t v;
    v.we = 1'(we); v.waddr = 5'(wa); v.wdata = wd;
    v.ra = 5'(ra); v.rea = 1'(rea); v.rb = 5'(rb); v.reb = 1'(reb);
    v.iss = 1'(iss); v.iwe = 1'(iwe); v.ird = 5'(ird); v.fl = 1'(fl);
    v.ea = ea; v.eb = eb; v.ehz = 1'(hz); v.erdy = 1'(rdy);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    we_i = v.we; waddr_i = v.waddr; wdata_i = v.wdata;
    raddr_a_i = v.ra; re_a_i = v.rea; raddr_b_i = v.rb; re_b_i = v.reb;
    issue_i = v.iss; issue_we_i = v.iwe; issue_rd_i = v.ird; flush_i = v.fl;
  endtask

  task automatic idle();
    drive(mk(0,0,0, 0,0, 0,0, 0,0,0, 0, 0,0,0,1));
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    #1;
    chk("rst hazard", 32'(hazard_o), 32'd0);
    chk("rst ready", 32'(issue_ready_o), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;

    // All registers read zero after reset on both ports.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      raddr_a_i = 5'(i); raddr_b_i = 5'(31 - i); re_a_i = 1'b1; re_b_i = 1'b1;
      #2;
      chk($sformatf("init rdata_a x%0d", i), rdata_a_o, 32'd0);
      chk($sformatf("init rdata_b x%0d", 31 - i), rdata_b_o, 32'd0);
      chk($sformatf("init hazard %0d", i), 32'(hazard_o), 32'd0);
      chk($sformatf("init ready %0d", i), 32'(issue_ready_o), 32'd1);
    end

    // mk(we,wa,wd, ra,rea, rb,reb, iss,iwe,ird, fl, exp_a,exp_b,exp_hz,exp_rdy)
    // write + bypass, x0 ignored
    vq.push_back(mk(0,0,0,            0,1, 31,1, 0,0,0, 0, 0,0,0,1));
    vq.push_back(mk(1,5,32'hDEADBEEF, 5,1, 0,0,  0,0,0, 0, 32'hDEADBEEF,0,0,1));
    vq.push_back(mk(0,0,0,            5,1, 5,0,  0,0,0, 0, 32'hDEADBEEF,32'hDEADBEEF,0,1));
    vq.push_back(mk(1,0,32'h1234,     0,1, 0,1,  0,0,0, 0, 0,0,0,1));
    vq.push_back(mk(0,0,0,            0,1, 5,1,  0,0,0, 0, 0,32'hDEADBEEF,0,1));
    // RAW hazard on x7 until write-back
    vq.push_back(mk(0,0,0,            7,1, 0,0,  1,1,7, 0, 0,0,0,1));
    vq.push_back(mk(0,0,0,            7,1, 0,0,  0,0,0, 0, 0,0,1,1));
    vq.push_back(mk(0,0,0,            7,0, 7,0,  0,0,0, 0, 0,0,0,1));
    vq.push_back(mk(1,7,32'h55,       7,1, 0,0,  0,0,0, 0, 32'h55,0,0,1));
    vq.push_back(mk(0,0,0,            7,1, 0,0,  0,0,0, 0, 32'h55,0,0,1));
    // saturate x3
    vq.push_back(mk(0,0,0,            0,0, 3,1,  1,1,3, 0, 0,0,0,1));
    vq.push_back(mk(0,0,0,            0,0, 3,1,  1,1,3, 0, 0,0,1,1));
    vq.push_back(mk(0,0,0,            0,0, 3,1,  1,1,3, 0, 0,0,1,1));
    vq.push_back(mk(0,0,0,            0,0, 3,1,  1,1,3, 0, 0,0,1,0));
    vq.push_back(mk(1,3,32'hAA,       0,0, 3,1,  1,1,3, 0, 0,32'hAA,1,1));
    vq.push_back(mk(0,0,0,            0,0, 3,1,  0,1,3, 0, 0,32'hAA,1,0));
    vq.push_back(mk(1,3,32'h1,        0,0, 3,1,  0,0,0, 0, 0,32'h1,1,1));
    vq.push_back(mk(1,3,32'h2,        0,0, 3,1,  0,0,0, 0, 0,32'h2,1,1));
    vq.push_back(mk(1,3,32'h3,        0,0, 3,1,  0,0,0, 0, 0,32'h3,0,1));
    vq.push_back(mk(0,0,0,            0,0, 3,1,  0,0,0, 0, 0,32'h3,0,1));
    vq.push_back(mk(1,3,32'h4,        0,0, 3,1,  0,0,0, 0, 0,32'h4,0,1));
    vq.push_back(mk(0,0,0,            3,1, 3,1,  1,1,0, 0, 32'h4,32'h4,0,1));
    vq.push_back(mk(0,0,0,            0,1, 0,1,  0,0,0, 0, 0,0,0,1));
    // two writers on x9
    vq.push_back(mk(0,0,0,            0,0, 9,1,  1,1,9, 0, 0,0,0,1));
    vq.push_back(mk(0,0,0,            0,0, 9,1,  1,1,9, 0, 0,0,1,1));
    vq.push_back(mk(1,9,32'h99,       0,0, 9,1,  0,0,0, 0, 0,32'h99,1,1));
    vq.push_back(mk(0,0,0,            0,0, 9,1,  0,0,0, 0, 0,32'h99,1,1));
    vq.push_back(mk(1,9,32'h9A,       0,0, 9,1,  0,0,0, 0, 0,32'h9A,0,1));
    vq.push_back(mk(0,0,0,            0,0, 9,1,  0,0,0, 0, 0,32'h9A,0,1));
    // flush with concurrent write-back and (ignored) issue
    vq.push_back(mk(0,0,0,            4,1, 8,1,  1,1,4, 0, 0,0,0,1));
    vq.push_back(mk(0,0,0,            4,1, 8,1,  1,1,8, 0, 0,0,1,1));
    vq.push_back(mk(0,0,0,            4,1, 8,1,  1,1,4, 0, 0,0,1,1));
    vq.push_back(mk(0,0,0,            4,1, 8,1,  0,0,0, 0, 0,0,1,1));
    vq.push_back(mk(1,4,32'h11,       4,1, 8,1,  1,1,8, 1, 32'h11,0,1,1));
    vq.push_back(mk(0,0,0,            4,1, 8,1,  0,0,0, 0, 32'h11,0,0,1));
    // leave x8 pending for the reset sequence
    vq.push_back(mk(0,0,0,            8,1, 0,0,  1,1,8, 0, 0,0,0,1));
    vq.push_back(mk(0,0,0,            8,1, 0,0,  0,0,0, 0, 0,0,1,1));

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #2;
      chk($sformatf("v%0d rdata_a", i), rdata_a_o, vq[i].ea);
      chk($sformatf("v%0d rdata_b", i), rdata_b_o, vq[i].eb);
      chk($sformatf("v%0d hazard", i), 32'(hazard_o), 32'(vq[i].ehz));
      chk($sformatf("v%0d ready", i), 32'(issue_ready_o), 32'(vq[i].erdy));
    end

    // Asynchronous reset mid-operation clears data and pending state at once.
    @(negedge clk);
    idle();
    raddr_a_i = 5'd5; re_a_i = 1'b1; raddr_b_i = 5'd8; re_b_i = 1'b1;
    #1;
    chk("pre-rst x5", rdata_a_o, 32'hDEADBEEF);
    chk("pre-rst hazard x8", 32'(hazard_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid-rst x5", rdata_a_o, 32'd0);
    chk("mid-rst hazard", 32'(hazard_o), 32'd0);
    raddr_a_i = 5'd7; raddr_b_i = 5'd3;
    #1;
    chk("mid-rst x7", rdata_a_o, 32'd0);
    chk("mid-rst x3", rdata_b_o, 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    raddr_a_i = 5'd4; raddr_b_i = 5'd8;
    #2;
    chk("post-rst x4", rdata_a_o, 32'd0);
    chk("post-rst hazard", 32'(hazard_o), 32'd0);
    chk("post-rst ready", 32'(issue_ready_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Integer register file with a per-register pending-write scoreboard. It is the consumer of the write-back stage's wdata/dest_reg/we outputs.
- Decode reads two operands and marks the destination pending at issue.
- Write-back retires the pending mark and writes the data.
- Provides write-through bypass and a hazard flag so decode can stall on RAW hazards.

Parameters:
- NUM_REGS, 32, number of architectural registers; x0 is hardwired to zero.
- PEND_W, 2, width of the per-register pending counter; max 2**PEND_W-1 in-flight writes per register.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- we_i  in  1  write-back write enable (from WB stage we_o)
- waddr_i  in  ADDR_WIDTH  write-back destination register (from dest_reg_o)
- wdata_i  in  DATA_WIDTH  write-back data (from wdata_o)
- raddr_a_i  in  ADDR_WIDTH  read port A address
- re_a_i  in  1  read port A used by current decode instruction
- rdata_a_o  out  DATA_WIDTH  read port A data
- raddr_b_i  in  ADDR_WIDTH  read port B address
- re_b_i  in  1  read port B used
- rdata_b_o  out  DATA_WIDTH  read port B data
- issue_i  in  1  instruction leaves decode this cycle
- issue_we_i  in  1  issuing instruction writes a register
- issue_rd_i  in  ADDR_WIDTH  issuing instruction's destination
- flush_i  in  1  pipeline flush; clears the scoreboard
- hazard_o  out  1  a used read operand has an outstanding write
- issue_ready_o  out  1  scoreboard can accept issue_rd_i

Behaviour:
- Clock and reset:
  - Single clock domain: clk_i. Reset rst_ni is asynchronous and active-low.
  - During and after reset, all registers read 0, all pending counters are 0, hazard_o=0 and issue_ready_o=1.
- Storage:
  - NUM_REGS-1 flops of DATA_WIDTH. Entry 0 is not stored.
  - Write on the rising edge when we_i=1 and waddr_i!=0. A write to x0 is ignored.
- Reads:
  - Combinational, zero latency. Address 0 returns 0.
  - Bypass: if we_i=1, waddr_i!=0 and waddr_i equals the read address, the read returns wdata_i in the same cycle.
- Pending counter cnt[r], per register, r=1..NUM_REGS-1, PEND_W bits:
  - inc = issue_i & issue_we_i & issue_rd_i!=0 & issue_ready_o & (issue_rd_i==r)
  - dec = we_i & (waddr_i==r) & cnt[r]!=0
  - Next state: cnt+1 if inc&!dec; cnt-1 if dec&!inc; otherwise unchanged. Simultaneous inc and dec on the same register leaves it unchanged.
  - A write-back to a register with cnt=0 writes the data and leaves cnt at 0; no underflow, no error.
  - cnt[0] is constant 0.
- hazard_o is combinational:
  - It is the OR over ports p in {A,B} of re_p & raddr_p!=0 & cnt[raddr_p]!=0 & !(we_i & waddr_i==raddr_p & cnt[raddr_p]==1).
  - A write-back retiring the last pending write in the current cycle does not raise a hazard, because the bypass supplies the data.
- issue_ready_o:
  - 0 when issue_we_i=1, issue_rd_i!=0 and cnt[issue_rd_i] is at max with no dec on that register this cycle; otherwise 1.
  - Issue with issue_ready_o=0 is ignored by the scoreboard. Decode must stall.
- flush_i:
  - On the edge, all cnt go to 0. Issue in the same cycle is ignored.
  - Write-back in the same cycle still writes the data.
  - Decode asserts flush only when every in-flight writer is squashed.
- Reset mid-operation: asynchronously returns storage and counters to 0. No partial write completes.
- No internal state machine beyond the counters. Latency: write visible via bypass in cycle 0 and from the array in cycle 1.

Decomposition:
- riscv_cpu_pkg holds DATA_WIDTH (32) and ADDR_WIDTH (5, register index width). Add NUM_REGS and PEND_W defaults there.
- One natural sub-module: sb_counter, a single per-register saturating up/down counter with inc/dec/clear and a max flag, instantiated NUM_REGS-1 times.
- The register array and bypass muxes stay in the top module.

Test Plan:
1. Reset, then read x0..x31 on both ports -> all 0; hazard_o=0, issue_ready_o=1.
2. Write x5=0xDEADBEEF with raddr_a=5 in the same cycle -> rdata_a=0xDEADBEEF that cycle (bypass). The next cycle also returns 0xDEADBEEF from the array. Writing x0=0x1234 -> x0 still reads 0.
3. Issue with rd=7, then re_a=1, raddr_a=7 -> hazard_o=1 until the write-back cycle of x7=0x55. In that cycle hazard_o=0 and rdata_a=0x55; afterwards cnt[7]=0.
4. Issue rd=3 three times (PEND_W=2) -> issue_ready_o=0 on a fourth attempt with rd=3. Issue rd=3 together with WB to x3 in the same cycle -> ready=1 and cnt stays 3.
5. Two issues to rd=9, then one WB to x9 -> hazard_o remains 1 for raddr_b=9, re_b=1. The second WB clears it.
6. Pending on x4 and x8, then flush_i together with WB x4=0x11 -> all cnt=0 next cycle, hazard_o=0, x4 reads 0x11. Assert rst_ni low mid-sequence -> all registers read 0 immediately.
